// File: rtl/data_island_scheduler_if.sv
// rtl/data_island_scheduler_if.sv - packet source and serializer/encoder signals of the data island scheduler
interface data_island_scheduler_if;
   logic        islandWindow;
   logic        packetValid;
   logic [23:0] packetHeader;
   logic [55:0] packetSubpacket0;
   logic [55:0] packetSubpacket1;
   logic [55:0] packetSubpacket2;
   logic [55:0] packetSubpacket3;
   logic        packetAccept;
   logic [23:0] header;
   logic [55:0] subpacket0;
   logic [55:0] subpacket1;
   logic [55:0] subpacket2;
   logic [55:0] subpacket3;
   logic        isFirstPacketClock;
   logic [1:0]  mode;
   logic [3:0]  ctl;
   logic        busy;

   modport master (
      output islandWindow, packetValid, packetHeader,
             packetSubpacket0, packetSubpacket1, packetSubpacket2, packetSubpacket3,
      input  packetAccept, header, subpacket0, subpacket1, subpacket2, subpacket3,
             isFirstPacketClock, mode, ctl, busy
   );

   modport slave (
      input  islandWindow, packetValid, packetHeader,
             packetSubpacket0, packetSubpacket1, packetSubpacket2, packetSubpacket3,
      output packetAccept, header, subpacket0, subpacket1, subpacket2, subpacket3,
             isFirstPacketClock, mode, ctl, busy
   );
endinterface

// File: rtl/data_island_scheduler.sv
// rtl/data_island_scheduler.sv - sequences one HDMI data island period and latches its packet
module data_island_scheduler #(
   parameter int MIN_CONTROL     = 4,
   parameter int PREAMBLE_CLOCKS = 8,
   parameter int GUARD_CLOCKS    = 2
) (
   input  logic                    i_clock,
   input  logic                    i_nReset,
   data_island_scheduler_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_LEAD_GUARD,
      S_PACKET,
      S_TRAIL_GUARD
   } state_t;

   // Start is decided one cycle ahead, so the decision cycle itself counts as CONTROL.
   localparam logic [7:0] CTRL_NEED = 8'(MIN_CONTROL - 1);
   localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_CLOCKS - 1);
   localparam logic [5:0] GRD_LAST  = 6'(GUARD_CLOCKS - 1);
   localparam logic [5:0] PKT_LAST  = 6'd31;

   state_t      r_state;
   logic [5:0]  r_phase;
   logic [7:0]  r_ctrl_cnt;
   logic        r_accept;
   logic        r_first;
   logic [1:0]  r_mode;
   logic [3:0]  r_ctl;
   logic        r_busy;
   logic [23:0] r_header;
   logic [55:0] r_sub0;
   logic [55:0] r_sub1;
   logic [55:0] r_sub2;
   logic [55:0] r_sub3;

   state_t      w_state_nxt;
   logic [5:0]  w_phase_nxt;
   logic [7:0]  w_ctrl_nxt;
   logic        w_start;
   logic        w_first_nxt;
   logic [1:0]  w_mode_nxt;
   logic [3:0]  w_ctl_nxt;

   always_ff @(posedge i_clock or negedge i_nReset) begin
      if (!i_nReset) begin
         r_state    <= S_IDLE;
         r_phase    <= 6'd0;
         r_ctrl_cnt <= 8'd0;
         r_accept   <= 1'b0;
         r_first    <= 1'b0;
         r_mode     <= 2'd0;
         r_ctl      <= 4'd0;
         r_busy     <= 1'b0;
         r_header   <= 24'd0;
         r_sub0     <= 56'd0;
         r_sub1     <= 56'd0;
         r_sub2     <= 56'd0;
         r_sub3     <= 56'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_phase    <= w_phase_nxt;
         r_ctrl_cnt <= w_ctrl_nxt;
         r_accept   <= w_start;
         r_first    <= w_first_nxt;
         r_mode     <= w_mode_nxt;
         r_ctl      <= w_ctl_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         if (w_start) begin
            r_header <= bus.packetHeader;
            r_sub0   <= bus.packetSubpacket0;
            r_sub1   <= bus.packetSubpacket1;
            r_sub2   <= bus.packetSubpacket2;
            r_sub3   <= bus.packetSubpacket3;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase + 6'd1;
      w_ctrl_nxt  = 8'd0;
      w_start     = 1'b0;
      w_first_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_phase_nxt = 6'd0;
            w_ctrl_nxt  = (r_ctrl_cnt == 8'hFF) ? r_ctrl_cnt : r_ctrl_cnt + 8'd1;
            if (bus.islandWindow && bus.packetValid && (r_ctrl_cnt >= CTRL_NEED)) begin
               w_start     = 1'b1;
               w_state_nxt = S_PREAMBLE;
            end
         end
         S_PREAMBLE: if (r_phase == PRE_LAST) begin
            w_state_nxt = S_LEAD_GUARD;
            w_phase_nxt = 6'd0;
         end
         S_LEAD_GUARD: if (r_phase == GRD_LAST) begin
            w_state_nxt = S_PACKET;
            w_phase_nxt = 6'd0;
            w_first_nxt = 1'b1;
         end
         S_PACKET: if (r_phase == PKT_LAST) begin
            w_state_nxt = S_TRAIL_GUARD;
            w_phase_nxt = 6'd0;
         end
         S_TRAIL_GUARD: if (r_phase == GRD_LAST) begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = 6'd0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = 6'd0;
         end
      endcase

      case (w_state_nxt)
         S_PREAMBLE:                  w_mode_nxt = 2'd1;
         S_LEAD_GUARD, S_TRAIL_GUARD: w_mode_nxt = 2'd2;
         S_PACKET:                    w_mode_nxt = 2'd3;
         default:                     w_mode_nxt = 2'd0;
      endcase
      w_ctl_nxt = (w_state_nxt == S_PREAMBLE) ? 4'b0101 : 4'b0000;
   end

   assign bus.packetAccept       = r_accept;
   assign bus.isFirstPacketClock = r_first;
   assign bus.mode               = r_mode;
   assign bus.ctl                = r_ctl;
   assign bus.busy               = r_busy;
   assign bus.header             = r_header;
   assign bus.subpacket0         = r_sub0;
   assign bus.subpacket1         = r_sub1;
   assign bus.subpacket2         = r_sub2;
   assign bus.subpacket3         = r_sub3;

endmodule

// File: tb/tb_data_island_scheduler.sv
// tb/tb_data_island_scheduler.sv - randomized bench for data_island_scheduler against an island-position model
module tb_data_island_scheduler;

   localparam int MIN_C = 4;
   localparam int PRE   = 8;
   localparam int GRD   = 2;
   localparam int TOTAL = PRE + 2 * GRD + 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_island_scheduler_if dif ();

   data_island_scheduler #(
      .MIN_CONTROL    (MIN_C),
      .PREAMBLE_CLOCKS(PRE),
      .GUARD_CLOCKS   (GRD)
   ) dut (
      .i_clock (clk),
      .i_nReset(rst_n),
      .bus     (dif.slave)
   );

   int total = 0;
   int bad   = 0;

   // Model: position within the island (-1 when in CONTROL) plus CONTROL cycles already elapsed.
   int          m_n;
   int          m_prior;
   logic [23:0] m_hdr;
   logic [55:0] m_sp [4];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_n     = -1;
      m_prior = 0;
      m_hdr   = '0;
      for (int k = 0; k < 4; k++) m_sp[k] = '0;
   endtask

   task automatic model_update();
      if (!rst_n) begin
         model_reset();
      end else if (m_n < 0) begin
         if (dif.islandWindow && dif.packetValid && (m_prior + 1 >= MIN_C)) begin
            m_n     = 0;
            m_hdr   = dif.packetHeader;
            m_sp[0] = dif.packetSubpacket0;
            m_sp[1] = dif.packetSubpacket1;
            m_sp[2] = dif.packetSubpacket2;
            m_sp[3] = dif.packetSubpacket3;
         end else if (m_prior < 255) begin
            m_prior++;
         end
      end else begin
         m_n++;
         if (m_n == TOTAL) begin
            m_n     = -1;
            m_prior = 0;
         end
      end
   endtask

   function automatic int exp_mode(input int n);
      if (n < 0)                  return 0;
      if (n < PRE)                return 1;
      if (n < PRE + GRD)          return 2;
      if (n < PRE + GRD + 32)     return 3;
      return 2;
   endfunction

   task automatic check_all();
      int md;
      md = exp_mode(m_n);
      chk("mode",   64'(dif.mode), 64'(md));
      chk("ctl",    64'(dif.ctl), (md == 1) ? 64'h5 : 64'h0);
      chk("accept", 64'(dif.packetAccept), 64'(m_n == 0));
      chk("first",  64'(dif.isFirstPacketClock), 64'(m_n == PRE + GRD));
      chk("busy",   64'(dif.busy), 64'(m_n >= 0));
      chk("header", 64'(dif.header), 64'(m_hdr));
      chk("sub0",   64'(dif.subpacket0), 64'(m_sp[0]));
      chk("sub1",   64'(dif.subpacket1), 64'(m_sp[1]));
      chk("sub2",   64'(dif.subpacket2), 64'(m_sp[2]));
      chk("sub3",   64'(dif.subpacket3), 64'(m_sp[3]));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   task automatic rand_packet();
      dif.packetHeader     = 24'($urandom);
      dif.packetSubpacket0 = 56'({$urandom, $urandom});
      dif.packetSubpacket1 = 56'({$urandom, $urandom});
      dif.packetSubpacket2 = 56'({$urandom, $urandom});
      dif.packetSubpacket3 = 56'({$urandom, $urandom});
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      step();
      rst_n = 1'b1;
   endtask

   int last_acc;
   int cyc;
   int seen;

   initial begin
      dif.islandWindow = 1'b1;
      dif.packetValid  = 1'b1;
      rand_packet();
      dif.packetHeader = 24'hA50102;
      model_reset();
      #1;
      check_all();

      // Release with window and valid already high: first accept at cycle MIN_C.
      @(negedge clk);
      rst_n = 1'b1;
      check_all();
      for (int i = 1; i <= 50; i++) begin
         step();
         if (i == MIN_C) begin
            chk("accept_at_min", 64'(dif.packetAccept), 64'h1);
            chk("header_a50102", 64'(dif.header), 64'hA50102);
         end
         if (i == MIN_C + PRE + GRD)
            chk("first_at_14", 64'(dif.isFirstPacketClock), 64'h1);
         if (i == MIN_C + TOTAL)
            chk("control_at_48", 64'(dif.mode), 64'h0);
         if (i == 10) rand_packet();
      end

      // Window held low with valid pending: no accept, then start the cycle after the window rises.
      dif.islandWindow = 1'b0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (dif.packetAccept) seen++;
      end
      chk("no_accept_window_low", 64'(seen), 64'h0);
      dif.islandWindow = 1'b1;
      step();
      chk("start_after_window", 64'(dif.packetAccept), 64'h1);

      // Continuous window/valid with new packets each island: accepts every TOTAL+MIN_C cycles.
      last_acc = 0;
      seen     = 0;
      for (int i = 1; i <= 200; i++) begin
         step();
         if (dif.packetAccept) begin
            if (seen > 0) chk("accept_gap", 64'(i - last_acc), 64'(TOTAL + MIN_C));
            last_acc = i;
            seen++;
            rand_packet();
         end else if (dif.mode == 2'd3) begin
            dif.packetHeader = 24'($urandom);
         end
      end
      chk("accept_count", 64'(seen >= 4), 64'h1);

      // Drop window and valid at n=20: island completes, no second accept.
      cyc = 0;
      while (m_n != 20 && cyc < 200) begin step(); cyc++; end
      chk("reach_n20", 64'(m_n == 20), 64'h1);
      dif.islandWindow = 1'b0;
      dif.packetValid  = 1'b0;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (dif.packetAccept) seen++;
      end
      chk("no_second_accept", 64'(seen), 64'h0);

      // Reset mid-island at n=15.
      dif.islandWindow = 1'b1;
      dif.packetValid  = 1'b1;
      rand_packet();
      cyc = 0;
      while (m_n != 15 && cyc < 200) begin step(); cyc++; end
      chk("reach_n15", 64'(m_n == 15), 64'h1);
      pulse_reset();
      chk("reset_mode", 64'(dif.mode), 64'h0);
      rand_packet();
      for (int i = 1; i <= TOTAL + MIN_C + 2; i++) begin
         step();
         if (i == MIN_C) chk("restart_accept", 64'(dif.packetAccept), 64'h1);
      end

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         dif.islandWindow = ($urandom_range(0, 3) != 0);
         dif.packetValid  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) rand_packet();
         if ($urandom_range(0, 299) == 0) pulse_reset();
         else step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_island_scheduler.md
Name: data_island_scheduler

Overview:
Sequences one HDMI data island period during horizontal/vertical blanking. Accepts a packet (header plus four subpackets) from an upstream packet source over a valid/accept handshake. Drives the period timing: control, data island preamble, leading guard band, 32 packet clocks, trailing guard band. Sits directly upstream of the data island packet serializer: supplies its isFirstPacketClock strobe and holds the packet fields stable, and drives mode/CTL selects to the channel encoder mux.

Parameters:
MIN_CONTROL, 4, minimum consecutive CONTROL-mode cycles before any PREAMBLE cycle (1..255)
PREAMBLE_CLOCKS, 8, length of data island preamble (1..15)
GUARD_CLOCKS, 2, length of each guard band (1..3)

Ports:
clock  in  1  system pixel clock; all logic on rising edge
nReset  in  1  asynchronous active-low reset
islandWindow  in  1  from timing generator; high when an island may start (room guaranteed by generator)
packetValid  in  1  source has a packet; data held stable until accepted
packetHeader  in  24  packet header bytes HB0..HB2, HB0 in [7:0]
packetSubpacket0..3  in  56 each  subpacket bytes SB0..SB6, SB0 in [7:0]
packetAccept  out  1  one-cycle pulse: packet latched
header  out  24  latched header to serializer
subpacket0..3  out  56 each  latched subpackets to serializer
isFirstPacketClock  out  1  high on first of 32 packet clocks only
mode  out  2  0 CONTROL, 1 PREAMBLE, 2 GUARD, 3 DATA
ctl  out  4  CTL3..CTL0: 4'b0101 during PREAMBLE, else 4'b0000
busy  out  1  high whenever mode != CONTROL

Behaviour:
- Reset (nReset low, async): state IDLE; all outputs 0 (mode=CONTROL, ctl=0, packetAccept=0, isFirstPacketClock=0, header/subpackets=0); control counter 0.
- States: IDLE -> PREAMBLE -> LEAD_GUARD -> PACKET -> TRAIL_GUARD -> IDLE. All outputs registered.
- IDLE: mode=CONTROL; control counter increments per cycle, saturating at 255. Start condition evaluated each cycle: islandWindow && packetValid && at least MIN_CONTROL CONTROL cycles will precede the first PREAMBLE cycle.
- Start: on the edge ending the decision cycle, latch all packet fields into header/subpacket outputs, enter PREAMBLE, and drive packetAccept=1 for exactly that first PREAMBLE cycle.
- Cycle numbering from the first PREAMBLE cycle (n=0):
  - PREAMBLE: n=0..PREAMBLE_CLOCKS-1
  - LEAD_GUARD: next GUARD_CLOCKS cycles
  - PACKET: next 32 cycles, isFirstPacketClock=1 on the first only
  - TRAIL_GUARD: next GUARD_CLOCKS cycles
  - then IDLE, control counter cleared to 0.
  - Defaults: PREAMBLE 0-7, guard 8-9, data 10-41 (first=10), guard 42-43, CONTROL from 44.
- Latched packet fields are constant from n=0 until the next accept. The serializer samples them on isFirstPacketClock.
- Exactly one packet per island; packetValid is ignored outside IDLE.
- islandWindow or packetValid dropping mid-island: ignored; the island always completes.
- Back-to-back: after TRAIL_GUARD, the next PREAMBLE no earlier than MIN_CONTROL CONTROL cycles later.
- Earliest start after reset release with valid and window already high: first PREAMBLE at cycle MIN_CONTROL (cycles 0..MIN_CONTROL-1 are CONTROL).
- Reset asserted mid-island: immediate return to IDLE with reset values; no partial accept is replayed.

Test Plan:
- Reset release, packetValid=1, islandWindow=1, header=24'hA50102 -> mode=0 for cycles 0-3; packetAccept and ctl=4'b0101 at cycle 4; mode=1 cycles 4-11, 2 at 12-13, 3 at 14-45, 2 at 46-47, 0 at 48; isFirstPacketClock only at 14; header=24'hA50102 from cycle 4.
- packetValid=1 with islandWindow=0 for 100 cycles, then window high -> no accept while low; PREAMBLE starts the cycle after window rises (counter saturated).
- Continuous valid/window with distinct packets -> each packetAccept separated by exactly 48 cycles (44 island + 4 CONTROL); latched data changes only at accept.
- Drop islandWindow and packetValid at n=20 -> island runs to n=43; no second accept.
- Assert nReset low at n=15 for 1 cycle -> all outputs 0 immediately; restart requires 4 CONTROL cycles; full 44-cycle island follows.
- Change packetHeader while in PACKET state -> header output unchanged until the next accept.
